pc_sequencer: RTL and testbench

- Program-counter stage directly upstream of the instruction fetch stage.
- Owns the PC register and selects the next PC: sequential +4, taken branch, or jump.
- Honours hazard-unit stalls and a halt request.
- Drives the fetch stage's PC and IF_Flush inputs, plus a fetch-valid qualifier and two saturating performance counters.

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/sat_counter.sv | 34 +++
 rtl/pc_sequencer.sv | 108 ++++++++++
 tb/tb_pc_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants.
// Used by the PC stage and its helpers.
package pipeline_pkg;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } pc_state_t;

   localparam int PC_WIDTH_DEFAULT = 6;
   localparam int PC_STEP          = 4;
   localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-low clear.
// Sticks at all-ones once reached.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: step when enabled, hold at all-ones.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// PC stage feeding instruction fetch.
// Owns the PC, next-PC mux, boot/run/halt FSM and perf counters.
module pc_sequencer
   import pipeline_pkg::*;
#(
   parameter int PC_WIDTH  = PC_WIDTH_DEFAULT,
   parameter int RESET_PC  = 0,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall,
   input  logic                 branch_taken,
   input  logic [PC_WIDTH-1:0]  branch_target,
   input  logic                 jump,
   input  logic [PC_WIDTH-1:0]  jump_target,
   input  logic                 halt,
   output logic [PC_WIDTH-1:0]  pc,
   output logic                 if_flush,
   output logic                 fetch_valid,
   output logic [CNT_WIDTH-1:0] redirect_count,
   output logic [CNT_WIDTH-1:0] stall_count
);

   localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

   pc_state_t           state_q;
   pc_state_t           state_d;
   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] pc_d;
   logic                redirect_inc;
   logic                stall_inc;
   logic                flush;

   // Next state, next PC, flush and counter enables.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      redirect_inc = 1'b0;
      stall_inc    = 1'b0;
      flush        = 1'b1;
      unique case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (stall) begin
               stall_inc = 1'b1;
               flush     = 1'b0;
            end else begin
               if (branch_taken) begin
                  pc_d         = branch_target & ALIGN_MASK;
                  redirect_inc = 1'b1;
               end else if (jump) begin
                  pc_d         = jump_target & ALIGN_MASK;
                  redirect_inc = 1'b1;
               end else begin
                  pc_d  = pc_q + PC_WIDTH'(PC_STEP);
                  flush = 1'b0;
               end
               if (halt) begin
                  state_d = HALTED;
               end
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // State and PC registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= PC_WIDTH'(RESET_PC);
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_redirect_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (redirect_inc),
      .count (redirect_count)
   );

   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .count (stall_count)
   );

   assign pc          = pc_q;
   assign if_flush    = flush;
   assign fetch_valid = (state_q == RUN) && !flush;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer.
// Driver pushes expected outputs; negedge monitor compares.
module tb_pc_sequencer;

   localparam int PW   = 6;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;
   localparam int PMOD = 1 << PW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          stall = 1'b0;
   logic          branch_taken = 1'b0;
   logic [PW-1:0] branch_target = '0;
   logic          jump = 1'b0;
   logic [PW-1:0] jump_target = '0;
   logic          halt = 1'b0;
   logic [PW-1:0] pc;
   logic          if_flush;
   logic          fetch_valid;
   logic [CW-1:0] redirect_count;
   logic [CW-1:0] stall_count;

   pc_sequencer #(
      .PC_WIDTH  (PW),
      .RESET_PC  (0),
      .CNT_WIDTH (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .jump           (jump),
      .jump_target    (jump_target),
      .halt           (halt),
      .pc             (pc),
      .if_flush       (if_flush),
      .fetch_valid    (fetch_valid),
      .redirect_count (redirect_count),
      .stall_count    (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pc;
      int fl;
      int fv;
      int rc;
      int sc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Reference model: 0=boot, 1=running, 2=halted.
   int m_pc;
   int m_mode;
   int m_rc;
   int m_sc;
   int halted_cycles;

   function automatic int sat_inc(int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   function automatic void model_reset();
      m_pc   = 0;
      m_mode = 0;
      m_rc   = 0;
      m_sc   = 0;
   endfunction

   function automatic void model_clock();
      if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (stall) begin
            m_sc = sat_inc(m_sc);
         end else begin
            if (branch_taken) begin
               m_pc = (int'(branch_target) / 4) * 4;
               m_rc = sat_inc(m_rc);
            end else if (jump) begin
               m_pc = (int'(jump_target) / 4) * 4;
               m_rc = sat_inc(m_rc);
            end else begin
               m_pc = (m_pc + 4) % PMOD;
            end
            if (halt) m_mode = 2;
         end
      end
   endfunction

   function automatic void push_exp();
      exp_t e;
      int   redir;
      redir = (!stall && (branch_taken || jump)) ? 1 : 0;
      e.fl  = (m_mode != 1 || redir == 1) ? 1 : 0;
      e.fv  = (m_mode == 1 && e.fl == 0) ? 1 : 0;
      e.pc  = m_pc;
      e.rc  = m_rc;
      e.sc  = m_sc;
      q.push_back(e);
   endfunction

   function automatic void cmp(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t",
                  name, act, req, $time);
      end
   endfunction

   task automatic drive(input bit s, input bit b, input int bt,
                        input bit j, input int jt, input bit h);
      @(posedge clk);
      if (rst_n) model_clock();
      #1;
      stall         = s;
      branch_taken  = b;
      branch_target = PW'(bt);
      jump          = j;
      jump_target   = PW'(jt);
      halt          = h;
      push_exp();
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic clear_inputs();
      stall        = 0;
      branch_taken = 0;
      jump         = 0;
      halt         = 0;
   endtask

   task automatic hold_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         rst_n = 0;
         clear_inputs();
         model_reset();
         push_exp();
      end
   endtask

   task automatic release_rst();
      @(posedge clk);
      #1;
      rst_n = 1;
      push_exp();
   endtask

   // Reset lands mid-cycle; monitor sees it before any further edge.
   task automatic async_reset();
      @(posedge clk);
      if (rst_n) model_clock();
      #2;
      rst_n = 0;
      clear_inputs();
      model_reset();
      push_exp();
   endtask

   // Monitor: compare every presented cycle against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            mon_e = q.pop_front();
            cmp("pc", int'(pc), mon_e.pc);
            cmp("if_flush", int'(if_flush), mon_e.fl);
            cmp("fetch_valid", int'(fetch_valid), mon_e.fv);
            cmp("redirect_count", int'(redirect_count), mon_e.rc);
            cmp("stall_count", int'(stall_count), mon_e.sc);
         end
      end
   end

   initial begin
      model_reset();
      halted_cycles = 0;

      hold_reset(3);
      release_rst();
      repeat (4) idle();

      for (int i = 0; i < 40 && m_pc != 56; i++) idle();
      repeat (3) idle();

      for (int i = 0; i < 40 && m_pc != 8; i++) idle();
      drive(1, 1, 36, 0, 0, 0);
      drive(0, 1, 36, 0, 0, 0);
      idle();

      drive(0, 1, 20, 1, 44, 0);
      idle();

      drive(0, 0, 0, 1, 47, 1);
      for (int i = 0; i < 10; i++) drive(0, 0, 0, i % 2 == 0, 12, 0);
      async_reset();
      hold_reset(2);
      release_rst();
      idle();

      repeat (20) drive(1, 0, 0, 0, 0, 0);
      repeat (2) idle();

      for (int i = 0; i < 600; i++) begin
         if ((m_mode == 2 && halted_cycles > 5) || (i % 97 == 96)) begin
            halted_cycles = 0;
            if (i % 2 == 0) begin
               async_reset();
               hold_reset(1);
            end else begin
               hold_reset(2);
            end
            release_rst();
         end else begin
            if (m_mode == 2) halted_cycles++;
            drive($urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, PMOD - 1),
                  $urandom_range(0, 3) == 0, $urandom_range(0, PMOD - 1),
                  $urandom_range(0, 29) == 0);
         end
      end

      for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
